// File: rtl/cluster_evt_bus_tx.sv
// Multi-channel SoC-to-cluster event bus producer. Per-channel hold registers feed a
// round-robin arbiter that writes one event per cycle into a toggle-token slot buffer.
// Channels can be disabled or set to lossy mode, where overflow is counted, not stalled.
module cluster_evt_bus_tx #(
  parameter int unsigned NB_CH        = 4,
  parameter int unsigned EVNT_WIDTH   = 8,
  parameter int unsigned BUFFER_WIDTH = 8,
  parameter int unsigned CNT_WIDTH    = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NB_CH-1:0]                   en_i,
  input  logic [NB_CH-1:0]                   drop_mode_i,
  input  logic [NB_CH-1:0]                   evt_valid_i,
  input  logic [NB_CH*EVNT_WIDTH-1:0]        evt_data_i,
  output logic [NB_CH-1:0]                   evt_ready_o,
  output logic [BUFFER_WIDTH-1:0]            events_wt_o,
  input  logic [BUFFER_WIDTH-1:0]            events_rp_i,
  output logic [BUFFER_WIDTH*EVNT_WIDTH-1:0] events_da_o,
  output logic [NB_CH*CNT_WIDTH-1:0]         drop_cnt_o,
  input  logic                               clr_cnt_i,
  output logic                               busy_o
);

  localparam int unsigned WpW = $clog2(BUFFER_WIDTH);
  localparam int unsigned RrW = (NB_CH > 1) ? $clog2(NB_CH) : 1;

  logic [NB_CH-1:0]                   hold_valid_q, hold_valid_d;
  logic [NB_CH-1:0][EVNT_WIDTH-1:0]   hold_data_q, hold_data_d;
  logic [WpW-1:0]                     wp_q, wp_d;
  logic [RrW-1:0]                     rr_q, rr_d;
  logic [BUFFER_WIDTH-1:0]            wt_q, wt_d;
  logic [BUFFER_WIDTH*EVNT_WIDTH-1:0] da_q, da_d;
  logic [NB_CH-1:0][CNT_WIDTH-1:0]    cnt_q, cnt_d;

  logic           slot_free;
  logic           grant;
  logic [RrW-1:0] winner;
  logic [RrW-1:0] arb_idx;
  logic [NB_CH-1:0] ready;
  logic [NB_CH-1:0] granted;
  logic [NB_CH-1:0] keep;
  logic [NB_CH-1:0] capture;
  logic [NB_CH-1:0] drop;

  // Round-robin pick among held events; only slot wp is eligible so writes stay in order.
  always_comb begin
    grant     = 1'b0;
    winner    = '0;
    arb_idx   = '0;
    slot_free = (wt_q[wp_q] == events_rp_i[wp_q]);
    for (int unsigned i = 0; i < NB_CH; i++) begin
      arb_idx = RrW'((32'(rr_q) + i) % NB_CH);
      if (slot_free && !grant && hold_valid_q[arb_idx]) begin
        grant  = 1'b1;
        winner = arb_idx;
      end
    end
  end

  // Per-channel handshake, hold update and drop accounting.
  always_comb begin
    ready        = '0;
    granted      = '0;
    keep         = '0;
    capture      = '0;
    drop         = '0;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    cnt_d        = cnt_q;
    for (int unsigned c = 0; c < NB_CH; c++) begin
      // Lossy channels always accept; overflow is dropped instead of stalling the source.
      ready[c]   = en_i[c] & (drop_mode_i[c] | ~hold_valid_q[c]);
      granted[c] = grant && (winner == RrW'(c));
      keep[c]    = hold_valid_q[c] & ~granted[c];
      capture[c] = evt_valid_i[c] & ready[c] & ~keep[c];
      drop[c]    = evt_valid_i[c] & ready[c] & keep[c];
      hold_valid_d[c] = capture[c] | keep[c];
      if (capture[c]) begin
        hold_data_d[c] = evt_data_i[c*EVNT_WIDTH +: EVNT_WIDTH];
      end
      if (clr_cnt_i) begin
        cnt_d[c] = '0;
      end else if (drop[c] && (cnt_q[c] != {CNT_WIDTH{1'b1}})) begin
        cnt_d[c] = cnt_q[c] + 1'b1;
      end
    end
  end

  // Slot write: toggle the write token and advance both pointers on a grant.
  always_comb begin
    wt_d = wt_q;
    da_d = da_q;
    wp_d = wp_q;
    rr_d = rr_q;
    if (grant) begin
      wt_d[wp_q]                          = ~wt_q[wp_q];
      da_d[wp_q*EVNT_WIDTH +: EVNT_WIDTH] = hold_data_q[winner];
      wp_d                                = wp_q + 1'b1;
      rr_d = (winner == RrW'(NB_CH - 1)) ? '0 : winner + 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hold_valid_q <= '0;
      hold_data_q  <= '0;
      wp_q         <= '0;
      rr_q         <= '0;
      wt_q         <= '0;
      da_q         <= '0;
      cnt_q        <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      wp_q         <= wp_d;
      rr_q         <= rr_d;
      wt_q         <= wt_d;
      da_q         <= da_d;
      cnt_q        <= cnt_d;
    end
  end

  assign evt_ready_o = ready;
  assign events_wt_o = wt_q;
  assign events_da_o = da_q;
  assign drop_cnt_o  = cnt_q;
  assign busy_o      = |hold_valid_q;

endmodule
